// File: rtl/bus_slave_regfile.sv
// ----------------------------------------------------------------------------
// bus_slave_regfile
//
// Register-file slave on the slv_* valid/ready bundle. A request seen in IDLE
// is latched, held for WAIT_CYCLES wait states, and completed with a one-cycle
// registered slv_ready pulse. Writes update the addressed register on the
// edge that enters the response cycle, and the response returns the new value.
// Addresses at or above NUM_REGS complete with slv_err=1 and slv_rdata=0, and
// a write to such an address is dropped.
//
// Ports
//   clock      in   1       rising-edge clock
//   reset      in   1       synchronous, active-high
//   slv_valid  in   1       request valid, held by the master until slv_ready
//   slv_write  in   1       1 = write, 0 = read
//   slv_addr   in   ADDR_W  register index
//   slv_wdata  in   DATA_W  write data
//   slv_rdata  out  DATA_W  read data, non-zero only in the response cycle
//   slv_ready  out  1       one-cycle completion pulse
//   slv_err    out  1       address error, qualified by slv_ready
//   busy       out  1       a transaction is in flight (WAIT or RESP)
// ----------------------------------------------------------------------------
module bus_slave_regfile #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              slv_valid,
    input  logic              slv_write,
    input  logic [ADDR_W-1:0] slv_addr,
    input  logic [DATA_W-1:0] slv_wdata,
    output logic [DATA_W-1:0] slv_rdata,
    output logic              slv_ready,
    output logic              slv_err,
    output logic              busy
);

    // The wait counter must hold WAIT_CYCLES; keep at least one bit so the
    // zero-wait configuration still elaborates.
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;

    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    logic [DATA_W-1:0]   r_rdata;
    logic                r_ready;
    logic                r_err;
    logic                r_busy;

    logic                w_accept;
    logic                w_req_write;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [DATA_W-1:0]   w_req_wdata;
    logic                w_addr_ok;
    logic [DATA_W-1:0]   w_reg_rd;
    logic                w_enter_resp;
    logic                w_do_write;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                w_err_nxt;
    logic                w_busy_nxt;

    assign w_accept = (r_state == S_IDLE) && slv_valid;

    // With zero wait states the response is entered on the accept edge itself,
    // so the live request fields are used in IDLE and the latched copy after.
    assign w_req_write = (r_state == S_IDLE) ? slv_write : r_write;
    assign w_req_addr  = (r_state == S_IDLE) ? slv_addr  : r_addr;
    assign w_req_wdata = (r_state == S_IDLE) ? slv_wdata : r_wdata;

    // One extra bit so NUM_REGS == 2**ADDR_W compares correctly and no
    // out-of-range address ever aliases onto an implemented register.
    assign w_addr_ok = ({1'b0, w_req_addr} < (ADDR_W + 1)'(NUM_REGS));

    always_comb begin
        w_reg_rd = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_req_addr == ADDR_W'(i)) begin
                w_reg_rd = r_regs[i];
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (slv_valid) begin
                    w_state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered response outputs
    always_comb begin
        w_enter_resp = (w_state_nxt == S_RESP);
        w_do_write   = w_enter_resp && w_req_write && w_addr_ok;
        w_err_nxt    = w_enter_resp && !w_addr_ok;
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_rdata_nxt  = '0;
        if (w_enter_resp && w_addr_ok) begin
            w_rdata_nxt = w_req_write ? w_req_wdata : w_reg_rd;
        end
    end

    // Request latch: captured only on accept, so WAIT ignores the bus.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_write <= slv_write;
            r_addr  <= slv_addr;
            r_wdata <= slv_wdata;
        end
    end

    // Register file: reset has priority, so a reset during WAIT drops the write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_do_write) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_req_addr == ADDR_W'(i)) begin
                    r_regs[i] <= w_req_wdata;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_rdata <= w_rdata_nxt;
            r_ready <= w_enter_resp;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign slv_rdata = r_rdata;
    assign slv_ready = r_ready;
    assign slv_err   = r_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bus_slave_regfile.sv
// ----------------------------------------------------------------------------
// tb_bus_slave_regfile
//
// Three slave instances with different parameter sets share one clock and
// reset:
//   u0: ADDR_W=4 DATA_W=8  NUM_REGS=8 WAIT_CYCLES=2
//   u1: ADDR_W=4 DATA_W=8  NUM_REGS=8 WAIT_CYCLES=0
//   u2: ADDR_W=3 DATA_W=16 NUM_REGS=5 WAIT_CYCLES=1
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// the same point, when the registered outputs describe the current cycle.
// ----------------------------------------------------------------------------
module tb_bus_slave_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vld [3];
    logic        wr  [3];
    logic [3:0]  ad  [3];
    logic [15:0] wd  [3];

    logic [7:0]  rd0, rd1;
    logic [15:0] rd2;
    logic        rdy0, rdy1, rdy2;
    logic        err0, err1, err2;
    logic        bsy0, bsy1, bsy2;

    int n_cmp  = 0;
    int n_fail = 0;

    bus_slave_regfile #(.ADDR_W(4), .DATA_W(8), .NUM_REGS(8), .WAIT_CYCLES(2)) u0 (
        .clock(clk), .reset(rst), .slv_valid(vld[0]), .slv_write(wr[0]),
        .slv_addr(ad[0]), .slv_wdata(wd[0][7:0]), .slv_rdata(rd0),
        .slv_ready(rdy0), .slv_err(err0), .busy(bsy0)
    );

    bus_slave_regfile #(.ADDR_W(4), .DATA_W(8), .NUM_REGS(8), .WAIT_CYCLES(0)) u1 (
        .clock(clk), .reset(rst), .slv_valid(vld[1]), .slv_write(wr[1]),
        .slv_addr(ad[1]), .slv_wdata(wd[1][7:0]), .slv_rdata(rd1),
        .slv_ready(rdy1), .slv_err(err1), .busy(bsy1)
    );

    bus_slave_regfile #(.ADDR_W(3), .DATA_W(16), .NUM_REGS(5), .WAIT_CYCLES(1)) u2 (
        .clock(clk), .reset(rst), .slv_valid(vld[2]), .slv_write(wr[2]),
        .slv_addr(ad[2][2:0]), .slv_wdata(wd[2]), .slv_rdata(rd2),
        .slv_ready(rdy2), .slv_err(err2), .busy(bsy2)
    );

    function automatic logic [15:0] rd_of(input int k);
        case (k)
            0:       return {8'h00, rd0};
            1:       return {8'h00, rd1};
            default: return rd2;
        endcase
    endfunction

    function automatic logic rdy_of(input int k);
        case (k)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic err_of(input int k);
        case (k)
            0:       return err0;
            1:       return err1;
            default: return err2;
        endcase
    endfunction

    function automatic logic bsy_of(input int k);
        case (k)
            0:       return bsy0;
            1:       return bsy1;
            default: return bsy2;
        endcase
    endfunction

    function automatic int wait_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int nregs_of(input int k);
        return (k == 2) ? 5 : 8;
    endfunction

    function automatic int amax_of(input int k);
        return (k == 2) ? 7 : 15;
    endfunction

    function automatic logic [15:0] dmask_of(input int k);
        return (k == 2) ? 16'hFFFF : 16'h00FF;
    endfunction

    // One full transaction on instance k. Starts with an idle step so it can
    // follow a previous response directly. lat counts cycles from the accept
    // edge to the ready cycle (1 = the cycle right after accept); -1 = timeout.
    task automatic txn(input int k, input logic w, input logic [3:0] a,
                       input logic [15:0] d, output logic [15:0] rdo,
                       output logic erro, output int lat);
        @(posedge clk); #1;
        vld[k] = 1'b1; wr[k] = w; ad[k] = a; wd[k] = d;
        @(posedge clk); #1;
        lat = 1;
        while (!rdy_of(k) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rdy_of(k)) lat = -1;
        rdo  = rd_of(k);
        erro = err_of(k);
        vld[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0; wr[k] = 1'b0; ad[k] = '0; wd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({rdy_of(k), err_of(k), bsy_of(k), rd_of(k)} !== 19'h0) begin
                n_fail++;
                $display("FAIL reset_hold u%0d: rdy/err/busy/rdata = %b/%b/%b/%h, required all 0",
                         k, rdy_of(k), err_of(k), bsy_of(k), rd_of(k));
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if ({rdy_of(k), err_of(k), bsy_of(k), rd_of(k)} !== 19'h0) begin
                    n_fail++;
                    $display("FAIL reset_idle u%0d cyc%0d: rdy/err/busy/rdata = %b/%b/%b/%h, required all 0",
                             k, c, rdy_of(k), err_of(k), bsy_of(k), rd_of(k));
                end
            end
        end
    endtask

    task automatic test_write_read();
        logic [15:0] r;
        logic        e;
        int          lat;
        logic        exp_bsy, exp_rdy;
        logic [7:0]  exp_rd;
        vld[0] = 1'b1; wr[0] = 1'b1; ad[0] = 4'd3; wd[0] = 16'h00A5;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            exp_bsy = (c <= 3);
            exp_rdy = (c == 3);
            exp_rd  = (c == 3) ? 8'hA5 : 8'h00;
            n_cmp++;
            if (bsy0 !== exp_bsy) begin
                n_fail++;
                $display("FAIL wr_busy cyc%0d: got %b, required %b", c, bsy0, exp_bsy);
            end
            n_cmp++;
            if (rdy0 !== exp_rdy) begin
                n_fail++;
                $display("FAIL wr_ready cyc%0d: got %b, required %b", c, rdy0, exp_rdy);
            end
            n_cmp++;
            if (rd0 !== exp_rd || err0 !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_rdata cyc%0d: rdata %h err %b, required %h err 0", c, rd0, err0, exp_rd);
            end
            if (c == 3) vld[0] = 1'b0;
        end
        txn(0, 1'b0, 4'd3, 16'h0, r, e, lat);
        n_cmp++;
        if (r !== 16'h00A5 || e !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL rd_addr3: rdata %h err %b lat %0d, required a5 0 3", r, e, lat);
        end
    endtask

    task automatic test_addr_err();
        logic [15:0] r;
        logic        e;
        int          lat;
        logic [15:0] v;
        txn(0, 1'b0, 4'd9, 16'h0, r, e, lat);
        n_cmp++;
        if (r !== 16'h0 || e !== 1'b1 || lat != 3) begin
            n_fail++;
            $display("FAIL rd_addr9: rdata %h err %b lat %0d, required 0 1 3", r, e, lat);
        end
        for (int i = 0; i < 8; i++) begin
            v = 16'(i * 17 + 1);
            txn(0, 1'b1, 4'(i), v, r, e, lat);
            n_cmp++;
            if (r !== v || e !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_wr%0d: rdata %h err %b, required %h 0", i, r, e, v);
            end
        end
        txn(0, 1'b1, 4'd9, 16'h00FF, r, e, lat);
        n_cmp++;
        if (r !== 16'h0 || e !== 1'b1 || lat != 3) begin
            n_fail++;
            $display("FAIL wr_addr9: rdata %h err %b lat %0d, required 0 1 3", r, e, lat);
        end
        for (int i = 0; i < 8; i++) begin
            v = 16'(i * 17 + 1);
            txn(0, 1'b0, 4'(i), 16'h0, r, e, lat);
            n_cmp++;
            if (r !== v || e !== 1'b0) begin
                n_fail++;
                $display("FAIL readback%0d: rdata %h err %b, required %h 0", i, r, e, v);
            end
        end
    endtask

    // Zero-wait instance, valid held high throughout; fields advance in each
    // response cycle. Transactions: W 11, R, W 22, R, W 33, R on address 0.
    task automatic test_back_to_back();
        int         t;
        logic       exp_rdy;
        logic [7:0] exp_rd;
        @(posedge clk); #1;
        vld[1] = 1'b1; wr[1] = 1'b1; ad[1] = 4'd0; wd[1] = 16'h0011;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            exp_rdy = (c % 2 == 1);
            n_cmp++;
            if (rdy1 !== exp_rdy || bsy1 !== exp_rdy) begin
                n_fail++;
                $display("FAIL b2b_ready cyc%0d: ready %b busy %b, required %b %b",
                         c, rdy1, bsy1, exp_rdy, exp_rdy);
            end
            if (exp_rdy) begin
                t = (c - 1) / 2;
                exp_rd = 8'(8'h11 * (t / 2 + 1));
                n_cmp++;
                if (rd1 !== exp_rd || err1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_rdata t%0d: rdata %h err %b, required %h 0", t, rd1, err1, exp_rd);
                end
                if (t + 1 < 6) begin
                    wr[1] = ((t + 1) % 2 == 0);
                    wd[1] = 16'(8'h11 * ((t + 1) / 2 + 1));
                end else begin
                    vld[1] = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        logic        e;
        int          lat;
        @(posedge clk); #1;
        vld[0] = 1'b1; wr[0] = 1'b1; ad[0] = 4'd1; wd[0] = 16'h003C;
        @(posedge clk); #1;
        n_cmp++;
        if (bsy0 !== 1'b1 || rdy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_wait: busy %b ready %b, required 1 0", bsy0, rdy0);
        end
        rst = 1'b1;
        vld[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (rdy0 !== 1'b0 || bsy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_noready cyc%0d: ready %b busy %b, required 0 0", c, rdy0, bsy0);
            end
            @(posedge clk); #1;
        end
        txn(0, 1'b0, 4'd1, 16'h0, r, e, lat);
        n_cmp++;
        if (r !== 16'h0 || e !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL rstmid_read: rdata %h err %b lat %0d, required 0 0 3", r, e, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] sh [8];
        logic [15:0] r, d, exp_rd;
        logic        e, w, exp_err;
        logic [3:0]  a;
        int          lat, hi;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) sh[i] = '0;
            hi = nregs_of(k) + 2;
            if (hi > amax_of(k)) hi = amax_of(k);
            for (int n = 0; n < 30; n++) begin
                w = 1'($urandom_range(0, 1));
                a = 4'($urandom_range(0, hi));
                d = 16'($urandom) & dmask_of(k);
                exp_err = (int'(a) >= nregs_of(k));
                exp_rd  = exp_err ? 16'h0 : (w ? d : sh[a[2:0]]);
                txn(k, w, a, d, r, e, lat);
                n_cmp++;
                if (lat != wait_of(k) + 1) begin
                    n_fail++;
                    $display("FAIL rnd_lat u%0d n%0d: latency %0d, required %0d", k, n, lat, wait_of(k) + 1);
                end
                n_cmp++;
                if (r !== exp_rd || e !== exp_err) begin
                    n_fail++;
                    $display("FAIL rnd_data u%0d n%0d w%b a%0d: rdata %h err %b, required %h %b",
                             k, n, w, a, r, e, exp_rd, exp_err);
                end
                if (w && !exp_err) sh[a[2:0]] = d;
                @(posedge clk); #1;
                n_cmp++;
                if ({rdy_of(k), err_of(k), bsy_of(k), rd_of(k)} !== 19'h0) begin
                    n_fail++;
                    $display("FAIL rnd_idle u%0d n%0d: rdy/err/busy/rdata = %b/%b/%b/%h, required all 0",
                             k, n, rdy_of(k), err_of(k), bsy_of(k), rd_of(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_addr_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
